fp_issue_ctrl: RTL and testbench
================================

# fp_issue_ctrl

Sequences floating-point instructions from the decode stage into the single, non-pipelined FPU and arbitrates the one FP register-file write port. FP-load writeback and FPU results compete for that port. The block issues one FPU operation at a time and tracks the pending destination register as a one-entry scoreboard. It stalls decode on structural and RAW/WAW hazards, handles flushes of in-flight operations, and raises an error if the FPU never responds. It sits between the decode-stage controller/FP register file and the FPU.

## Interface

**Parameters**
- TIMEOUT, 64: maximum cycles from `fpu_start` to `fpu_done` before abort; must be ≥2.
- CNT_W, 7: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

**Ports**
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  decode presents an FP instruction (StartF).
- op_i  in  4  FPU operation code (fp_operation).
- we_i  in  1  the instruction writes the FP register file (decoder_fp_we).
- rd_i, rs1_i, rs2_i, rs3_i  in  5 each  destination and source FP register indices.
- use_rs3_i  in  1  rs3 is a real source (fused ops).
- flush_i  in  1  squash the decode-stage instruction and any in-flight operation.
- fld_we_i  in  1  FP-load writeback request.
- fld_rd_i  in  5  FP-load destination register.
- fld_data_i  in  32  FP-load data.
- fpu_done_i  in  1  one-cycle pulse from the FPU when its result is valid.
- fpu_result_i  in  32  FPU result, valid with `fpu_done_i`.
- stall_d_o  out  1  hold the decode stage.
- fpu_start_o  out  1  one-cycle start pulse to the FPU.
- fpu_op_o  out  4  latched opcode, stable from `fpu_start_o` until done or abort.
- rf_we_o  out  1  FP register-file write enable.
- rf_waddr_o  out  5  FP register-file write address.
- rf_wdata_o  out  32  FP register-file write data.
- busy_o  out  1  state is not IDLE.
- timeout_o  out  1  one-cycle pulse when the watchdog expires.

## Operation

**States:** IDLE, ISSUE, BUSY, HOLD, DRAIN.

**Accept condition:**
- accept = start_i & !flush_i & state==IDLE & !hazard.
- On accept, latch op_i, rd_i and we_i as p_op, p_rd, p_we, then go to ISSUE.

**Hazard** (evaluated only when state != IDLE and p_we=1):
- rs1_i==p_rd, or rs2_i==p_rd, or (use_rs3_i & rs3_i==p_rd), or (we_i & rd_i==p_rd).
- Register f0 is not special: it participates in the hazard compare.

**stall_d_o:**
- Asserted = start_i & !flush_i & (state != IDLE | hazard).
- Combinational.

**State behaviour:**
- **ISSUE:** `fpu_start_o`=1 for exactly this cycle; clear the watchdog; go to BUSY.
- **BUSY:** the watchdog increments every cycle.
  - On fpu_done_i with p_we=0: go to IDLE, no write.
  - On fpu_done_i with p_we=1 and fld_we_i=0: write the FPU result this cycle (`rf_we_o`=1, addr=p_rd, data=fpu_result_i); go to IDLE.
  - On fpu_done_i with p_we=1 and fld_we_i=1: the load wins. Capture fpu_result_i into the hold register and go to HOLD.
- **HOLD:** write the hold register to p_rd in the first cycle with fld_we_i=0, then go to IDLE. The load keeps priority on every cycle.
- **Flush in ISSUE or BUSY:** go to DRAIN. A done pulse arriving in that same cycle is discarded.
- **DRAIN:** wait for fpu_done_i, discard the result, go to IDLE. The watchdog stays active.
- **Flush in HOLD:** ignored. The operation has completed architecturally and its result is still written.
- **Watchdog:** when the count reaches TIMEOUT in BUSY or DRAIN, pulse `timeout_o` and go to IDLE with no write. A later stray fpu_done_i in IDLE is ignored.

**FP-load writeback:**
- fld_we_i always drives the port immediately: `rf_we_o`=1, addr=fld_rd_i, data=fld_data_i.
- A load to p_rd while the operation is pending still writes. The FPU result then overwrites it later (program order guarantees the FPU op is younger only if decode issued it later; the pipeline guarantees this).

## Timing

- **Reset values:** state=IDLE, watchdog=0, p_op=0, p_rd=0, p_we=0. Outputs `stall_d_o`, `fpu_start_o`, `rf_we_o`, `busy_o`, `timeout_o` are 0; `fpu_op_o`, `rf_waddr_o`, `rf_wdata_o` are 0.
- **Reset mid-operation:** return to IDLE next edge. Any in-flight FPU result arriving afterwards is ignored.
- **Accept to start:** `fpu_start_o` rises one cycle after the accept edge.
- **Done to write:** the FPU write is in the same cycle as fpu_done_i (zero latency) when the port is free. Otherwise it lands 1+N cycles later, where N is the number of consecutive load writes.
- **Back-to-back issue:** a new instruction can be accepted in the cycle after the write. The minimum spacing is start-accept, ISSUE, BUSY(done) → next accept.
- **Watchdog:** expires TIMEOUT cycles after the ISSUE cycle.
- **Single-writer guarantee:** `rf_we_o` has at most one source per cycle; a dual write never occurs.

## Test plan

- **Basic issue:** start_i, op=4'h2, rd=5, done 3 cycles after `fpu_start_o` with result 32'h3F800000 → `fpu_start_o` pulses once; write f5=3F800000 in the done cycle; `busy_o` falls the next cycle.
- **RAW stall:** op pending to rd=5, next instruction has rs2=5 → `stall_d_o`=1 until the cycle after the write. With rs3=5 and use_rs3_i=0 → no stall.
- **Port collision:** done with result A and fld_we_i (rd=9, data B) in the same cycle, then fld_we_i held 2 more cycles → f9 gets B immediately; p_rd gets A exactly 3 cycles after done.
- **Flush:** flush_i asserted in BUSY, done arrives 2 cycles later → no `rf_we_o`; IDLE the cycle after done; a new start accepted.
- **Timeout:** TIMEOUT=64 with no done → `timeout_o` pulses once, 64 cycles after ISSUE; no write; a late done is ignored.
- **Reset mid-BUSY:** rst asserted → next cycle all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/fp_issue_ctrl.sv
// Issues FP operations one at a time to a non-pipelined FPU, keeps the pending destination as a
// one-entry scoreboard, and shares the single FP register-file write port with FP-load writeback.
// Handshake: fpu_start_o is a one-cycle request with no ready; fpu_done_i is a one-cycle response
// with no back-pressure; fld_we_i is never stalled and always owns the write port when asserted.
module fp_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [3:0]  op_i,
    input  logic        we_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rs3_i,
    input  logic        use_rs3_i,
    input  logic        flush_i,
    input  logic        fld_we_i,
    input  logic [4:0]  fld_rd_i,
    input  logic [31:0] fld_data_i,
    input  logic        fpu_done_i,
    input  logic [31:0] fpu_result_i,
    output logic        stall_d_o,
    output logic        fpu_start_o,
    output logic [3:0]  fpu_op_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] wd_cnt;
    logic [3:0]       p_op;
    logic [4:0]       p_rd;
    logic             p_we;
    logic [31:0]      hold_q;

    logic             hazard;
    logic             accept;
    logic             wd_expire;
    logic             fpu_we;
    logic [31:0]      fpu_wdata;
    logic             capture_hold;

    assign hazard = (state != IDLE) && p_we &&
                    ((rs1_i == p_rd) || (rs2_i == p_rd) ||
                     (use_rs3_i && (rs3_i == p_rd)) || (we_i && (rd_i == p_rd)));
    assign accept    = start_i && !flush_i && (state == IDLE) && !hazard;
    assign stall_d_o = start_i && !flush_i && ((state != IDLE) || hazard);
    // ISSUE clears the count, so it reads TIMEOUT-1 exactly TIMEOUT cycles after ISSUE.
    assign wd_expire = (wd_cnt == CNT_W'(TIMEOUT - 1));

    assign busy_o      = (state != IDLE);
    assign fpu_op_o    = p_op;
    assign dbg_state_o = state;

    always_comb begin
        state_nx     = state;
        fpu_start_o  = 1'b0;
        timeout_o    = 1'b0;
        fpu_we       = 1'b0;
        fpu_wdata    = '0;
        capture_hold = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nx = ISSUE;
            end
            ISSUE: begin
                fpu_start_o = 1'b1;
                state_nx    = flush_i ? DRAIN : BUSY;
            end
            BUSY: begin
                if (fpu_done_i) begin
                    // A flush coinciding with done discards the result; the FPU is already free.
                    if (flush_i || !p_we) begin
                        state_nx = IDLE;
                    end else if (!fld_we_i) begin
                        fpu_we    = 1'b1;
                        fpu_wdata = fpu_result_i;
                        state_nx  = IDLE;
                    end else begin
                        capture_hold = 1'b1;
                        state_nx     = HOLD;
                    end
                end else if (wd_expire) begin
                    timeout_o = 1'b1;
                    state_nx  = IDLE;
                end else if (flush_i) begin
                    state_nx = DRAIN;
                end
            end
            HOLD: begin
                if (!fld_we_i) begin
                    fpu_we    = 1'b1;
                    fpu_wdata = hold_q;
                    state_nx  = IDLE;
                end
            end
            DRAIN: begin
                if (fpu_done_i) begin
                    state_nx = IDLE;
                end else if (wd_expire) begin
                    timeout_o = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Loads always win the port; the FPU source only writes when the load is idle.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (fld_we_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = fld_rd_i;
            rf_wdata_o = fld_data_i;
        end else if (fpu_we) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = p_rd;
            rf_wdata_o = fpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wd_cnt <= '0;
            p_op   <= '0;
            p_rd   <= '0;
            p_we   <= 1'b0;
            hold_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                p_op <= op_i;
                p_rd <= rd_i;
                p_we <= we_i;
            end
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if ((state == BUSY) || (state == DRAIN)) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (capture_hold) hold_q <= fpu_result_i;
        end
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: directed scenarios plus a randomized run checked against a
// cycle-level model that tracks the pending operation by its age since acceptance.
module tb_fp_issue_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [3:0]  op_i;
    logic        we_i;
    logic [4:0]  rd_i, rs1_i, rs2_i, rs3_i;
    logic        use_rs3_i;
    logic        flush_i;
    logic        fld_we_i;
    logic [4:0]  fld_rd_i;
    logic [31:0] fld_data_i;
    logic        fpu_done_i;
    logic [31:0] fpu_result_i;
    logic        stall_d_o;
    logic        fpu_start_o;
    logic [3:0]  fpu_op_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        busy_o;
    logic        timeout_o;
    logic [2:0]  dbg_state_o;

    int total = 0;
    int bad   = 0;

    // reference model: the pending operation and its age in cycles since acceptance
    bit          m_active, m_sq, m_have, m_we;
    int          m_age;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    logic [31:0] m_res;

    bit          e_stall, e_start, e_rf_we, e_busy, e_to;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_op;

    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    fp_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .we_i(we_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i), .use_rs3_i(use_rs3_i),
        .flush_i(flush_i), .fld_we_i(fld_we_i), .fld_rd_i(fld_rd_i), .fld_data_i(fld_data_i),
        .fpu_done_i(fpu_done_i), .fpu_result_i(fpu_result_i),
        .stall_d_o(stall_d_o), .fpu_start_o(fpu_start_o), .fpu_op_o(fpu_op_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .busy_o(busy_o), .timeout_o(timeout_o), .dbg_state_o(dbg_state_o)
    );

    task automatic model_eval();
        bit          hz, fw;
        logic [31:0] fd;
        hz = m_active && m_we && ((rs1_i == m_rd) || (rs2_i == m_rd) ||
             (use_rs3_i && rs3_i == m_rd) || (we_i && rd_i == m_rd));
        e_busy  = m_active;
        e_op    = m_op;
        e_stall = start_i && !flush_i && (m_active || hz);
        e_start = m_active && (m_age == 1);
        e_to    = 1'b0;
        fw      = 1'b0;
        fd      = '0;
        if (m_active && m_age >= 2) begin
            if (m_have) begin
                if (!fld_we_i) begin fw = 1'b1; fd = m_res; end
            end else if (fpu_done_i) begin
                if (!m_sq && !flush_i && m_we && !fld_we_i) begin fw = 1'b1; fd = fpu_result_i; end
            end else if (m_age == TIMEOUT + 1) begin
                e_to = 1'b1;
            end
        end
        if (fld_we_i) begin
            e_rf_we = 1'b1; e_addr = fld_rd_i; e_data = fld_data_i;
        end else if (fw) begin
            e_rf_we = 1'b1; e_addr = m_rd; e_data = fd;
        end else begin
            e_rf_we = 1'b0; e_addr = '0; e_data = '0;
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            m_active = 0; m_sq = 0; m_have = 0; m_we = 0; m_age = 0;
            m_op = '0; m_rd = '0; m_res = '0;
        end else if (!m_active) begin
            if (start_i && !flush_i) begin
                m_active = 1; m_age = 1; m_sq = 0; m_have = 0;
                m_op = op_i; m_rd = rd_i; m_we = we_i;
            end
        end else if (m_age == 1) begin
            if (flush_i) m_sq = 1;
            m_age = 2;
        end else if (m_have) begin
            if (!fld_we_i) m_active = 0;
        end else if (fpu_done_i) begin
            if (!m_sq && !flush_i && m_we && fld_we_i) begin
                m_have = 1; m_res = fpu_result_i;
            end else begin
                m_active = 0;
            end
        end else if (m_age == TIMEOUT + 1) begin
            m_active = 0;
        end else begin
            if (flush_i) m_sq = 1;
            m_age++;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic edge_step();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start_i = 0; op_i = '0; we_i = 0; rd_i = '0; rs1_i = '0; rs2_i = '0; rs3_i = '0;
        use_rs3_i = 0; flush_i = 0; fld_we_i = 0; fld_rd_i = '0; fld_data_i = '0;
        fpu_done_i = 0; fpu_result_i = '0;
    endtask

    task automatic issue_op(input logic [3:0] op, input logic [4:0] rd, input logic we);
        start_i = 1; op_i = op; rd_i = rd; we_i = we;
        settle();
        edge_step();
        start_i = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        settle(); edge_step();
        settle(); edge_step();
        rst = 0;
        settle();
        total++; if ({stall_d_o, fpu_start_o, rf_we_o, busy_o, timeout_o} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {stall_d_o, fpu_start_o, rf_we_o, busy_o, timeout_o});
        end
        total++; if (fpu_op_o !== 4'h0) begin bad++; $display("FAIL reset_op got=%h want=0", fpu_op_o); end
        total++; if ({rf_waddr_o, rf_wdata_o} !== 37'h0) begin
            bad++; $display("FAIL reset_port got=%h/%h want=0/0", rf_waddr_o, rf_wdata_o);
        end
        edge_step();
    endtask

    task automatic test_basic();
        int starts = 0;
        issue_op(4'h2, 5'd5, 1'b1);
        settle();
        starts += int'(fpu_start_o);
        total++; if (fpu_start_o !== 1'b1) begin bad++; $display("FAIL basic_start got=%b want=1", fpu_start_o); end
        total++; if (fpu_op_o !== 4'h2) begin bad++; $display("FAIL basic_op got=%h want=2", fpu_op_o); end
        edge_step();
        for (int i = 1; i <= 3; i++) begin
            fpu_done_i   = (i == 3);
            fpu_result_i = (i == 3) ? 32'h3F80_0000 : 32'h0;
            settle();
            starts += int'(fpu_start_o);
            if (i == 3) begin
                total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd5, 32'h3F80_0000}) begin
                    bad++; $display("FAIL basic_write got=%b/%0d/%h want=1/5/3f800000", rf_we_o, rf_waddr_o, rf_wdata_o);
                end
            end else begin
                total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL basic_early_we got=%b want=0", rf_we_o); end
            end
            edge_step();
        end
        fpu_done_i = 0;
        settle();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy_fall got=%b want=0", busy_o); end
        total++; if (starts != 1) begin bad++; $display("FAIL basic_start_count got=%0d want=1", starts); end
        edge_step();
    endtask

    task automatic test_raw_stall();
        issue_op(4'h1, 5'd5, 1'b1);
        start_i = 1; op_i = 4'h3; rd_i = 5'd6; we_i = 1; rs1_i = 5'd1; rs2_i = 5'd5;
        for (int i = 0; i < 4; i++) begin
            fpu_done_i   = (i == 3);
            fpu_result_i = 32'h4000_0000;
            settle();
            total++; if (stall_d_o !== 1'b1) begin bad++; $display("FAIL raw_stall cyc=%0d got=%b want=1", i, stall_d_o); end
            if (i == 3) begin
                total++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd5}) begin
                    bad++; $display("FAIL raw_write got=%b/%0d want=1/5", rf_we_o, rf_waddr_o);
                end
            end
            edge_step();
        end
        fpu_done_i = 0;
        settle();
        total++; if (stall_d_o !== 1'b0) begin bad++; $display("FAIL raw_release got=%b want=0", stall_d_o); end
        edge_step();
        start_i = 0; rs1_i = '0; rs2_i = '0;
        settle();
        total++; if ({fpu_start_o, fpu_op_o} !== {1'b1, 4'h3}) begin
            bad++; $display("FAIL raw_second_issue got=%b/%h want=1/3", fpu_start_o, fpu_op_o);
        end
        edge_step();
        // rs3 without use_rs3 is not a source; stall comes only from the busy FPU
        start_i = 1; rd_i = 5'd2; we_i = 0; rs3_i = 5'd6; use_rs3_i = 0;
        fpu_done_i = 1; fpu_result_i = 32'hC000_0000;
        settle();
        total++; if ({stall_d_o, rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 1'b1, 5'd6, 32'hC000_0000}) begin
            bad++; $display("FAIL raw_second_write got=%b/%b/%0d/%h want=1/1/6/c0000000", stall_d_o, rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        edge_step();
        fpu_done_i = 0;
        settle();
        total++; if (stall_d_o !== 1'b0) begin bad++; $display("FAIL raw_rs3_unused got=%b want=0", stall_d_o); end
        edge_step();
        start_i = 0; rs3_i = '0;
        settle(); edge_step();
        fpu_done_i = 1;
        settle();
        total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL raw_no_we got=%b want=0", rf_we_o); end
        edge_step();
        fpu_done_i = 0;
    endtask

    task automatic test_collision();
        issue_op(4'h4, 5'd3, 1'b1);
        settle(); edge_step();
        fpu_done_i = 1; fpu_result_i = 32'hAAAA_5555;
        fld_we_i = 1; fld_rd_i = 5'd9; fld_data_i = 32'h1234_5678;
        settle();
        total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd9, 32'h1234_5678}) begin
            bad++; $display("FAIL coll_load got=%b/%0d/%h want=1/9/12345678", rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        edge_step();
        fpu_done_i = 0; fpu_result_i = '0;
        for (int k = 1; k <= 2; k++) begin
            fld_data_i = 32'h1234_5678 + 32'(k);
            settle();
            total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd9, 32'h1234_5678 + 32'(k)}) begin
                bad++; $display("FAIL coll_load_hold k=%0d got=%b/%0d/%h", k, rf_we_o, rf_waddr_o, rf_wdata_o);
            end
            edge_step();
        end
        fld_we_i = 0;
        settle();
        total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd3, 32'hAAAA_5555}) begin
            bad++; $display("FAIL coll_late_write got=%b/%0d/%h want=1/3/aaaa5555", rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        edge_step();
        settle();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL coll_idle got=%b want=0", busy_o); end
        edge_step();
    endtask

    task automatic test_flush();
        issue_op(4'h5, 5'd7, 1'b1);
        settle(); edge_step();
        flush_i = 1;
        settle();
        total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL flush_we0 got=%b want=0", rf_we_o); end
        edge_step();
        flush_i = 0;
        settle(); edge_step();
        fpu_done_i = 1; fpu_result_i = 32'hDEAD_BEEF;
        settle();
        total++; if ({rf_we_o, busy_o} !== 2'b01) begin
            bad++; $display("FAIL flush_discard got=we%b/busy%b want=we0/busy1", rf_we_o, busy_o);
        end
        edge_step();
        fpu_done_i = 0;
        start_i = 1; op_i = 4'h6; rd_i = 5'd8; we_i = 0;
        settle();
        total++; if ({busy_o, stall_d_o} !== 2'b00) begin
            bad++; $display("FAIL flush_reaccept got=busy%b/stall%b want=0/0", busy_o, stall_d_o);
        end
        edge_step();
        start_i = 0;
        settle();
        total++; if ({fpu_start_o, fpu_op_o} !== {1'b1, 4'h6}) begin
            bad++; $display("FAIL flush_new_start got=%b/%h want=1/6", fpu_start_o, fpu_op_o);
        end
        edge_step();
        fpu_done_i = 1;
        settle(); edge_step();
        fpu_done_i = 0;
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int first_at = -1;
        bit wrote = 0;
        issue_op(4'h7, 5'd10, 1'b1);
        for (int i = 0; i < 80; i++) begin
            settle();
            if (timeout_o) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
            if (rf_we_o) wrote = 1;
            edge_step();
        end
        total++; if (first_at != TIMEOUT) begin bad++; $display("FAIL timeout_at got=%0d want=%0d", first_at, TIMEOUT); end
        total++; if (pulses != 1) begin bad++; $display("FAIL timeout_pulses got=%0d want=1", pulses); end
        total++; if (wrote != 0) begin bad++; $display("FAIL timeout_write got=%0d want=0", wrote); end
        fpu_done_i = 1; fpu_result_i = 32'h1111_2222;
        settle();
        total++; if ({rf_we_o, busy_o} !== 2'b00) begin
            bad++; $display("FAIL timeout_late_done got=we%b/busy%b want=0/0", rf_we_o, busy_o);
        end
        edge_step();
        fpu_done_i = 0;
    endtask

    task automatic test_reset_mid_busy();
        issue_op(4'h8, 5'd11, 1'b1);
        settle(); edge_step();
        settle(); edge_step();
        rst = 1;
        settle(); edge_step();
        rst = 0;
        settle();
        total++; if ({stall_d_o, fpu_start_o, rf_we_o, busy_o, timeout_o, fpu_op_o, rf_waddr_o, rf_wdata_o} !== 46'h0) begin
            bad++; $display("FAIL rst_mid got=%b%b%b%b%b/%h/%h/%h want=all 0", stall_d_o, fpu_start_o, rf_we_o,
                            busy_o, timeout_o, fpu_op_o, rf_waddr_o, rf_wdata_o);
        end
        edge_step();
        fpu_done_i = 1; fpu_result_i = 32'h5555_AAAA;
        settle();
        total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL rst_stray_done got=%b want=0", rf_we_o); end
        edge_step();
        fpu_done_i = 0;
    endtask

    task automatic test_random();
        logic [36:0] got;
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            start_i      = ($urandom_range(0, 2) == 0);
            op_i         = 4'($urandom_range(0, 15));
            we_i         = 1'($urandom_range(0, 1));
            rd_i         = 5'($urandom_range(0, 7));
            rs1_i        = 5'($urandom_range(0, 7));
            rs2_i        = 5'($urandom_range(0, 7));
            rs3_i        = 5'($urandom_range(0, 7));
            use_rs3_i    = 1'($urandom_range(0, 1));
            flush_i      = ($urandom_range(0, 15) == 0);
            fld_we_i     = ($urandom_range(0, 3) == 0);
            fld_rd_i     = 5'($urandom_range(0, 31));
            fld_data_i   = $urandom;
            fpu_done_i   = ($urandom_range(0, 5) == 0);
            fpu_result_i = $urandom;
            settle();
            total++; if (stall_d_o !== e_stall) begin bad++; $display("FAIL rnd_stall c=%0d got=%b want=%b", c, stall_d_o, e_stall); end
            total++; if (fpu_start_o !== e_start) begin bad++; $display("FAIL rnd_start c=%0d got=%b want=%b", c, fpu_start_o, e_start); end
            total++; if (busy_o !== e_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy_o, e_busy); end
            total++; if (timeout_o !== e_to) begin bad++; $display("FAIL rnd_timeout c=%0d got=%b want=%b", c, timeout_o, e_to); end
            total++; if (fpu_op_o !== e_op) begin bad++; $display("FAIL rnd_op c=%0d got=%h want=%h", c, fpu_op_o, e_op); end
            total++; if (rf_we_o !== e_rf_we) begin bad++; $display("FAIL rnd_we c=%0d got=%b want=%b", c, rf_we_o, e_rf_we); end
            if (e_rf_we) exp_q.push_back({e_addr, e_data});
            if (rf_we_o === 1'b1) begin
                got = {rf_waddr_o, rf_wdata_o};
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rnd_write c=%0d got=%h want=none", c, got);
                end else if (exp_q[0] !== got) begin
                    bad++; $display("FAIL rnd_write c=%0d got=%h want=%h", c, got, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            edge_step();
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_leftover got=%0d want=0", exp_q.size()); end
        clear_inputs();
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_basic();
        test_raw_stall();
        test_collision();
        test_flush();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
